bit_serial_adder: RTL and testbench
===================================

// Module: bit_serial_adder
// PURPOSE
//  Bit-serial adder: adds two WIDTH-bit operands LSB-first, one bit per clock,
//  through a single full-adder cell (a^b^c / majority carry) with a registered carry.
//  Sits directly downstream of the operand source and wraps the full-adder cell
//  in a sequential datapath. Trades WIDTH cycles of latency for one FA cell.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits; legal range 1..32
// PORTS
//  clk      in   1      single clock; all state updates on posedge clk
//  rst      in   1      synchronous, active-high reset
//  start    in   1      request: sample a, b, cin and begin an add (honoured in IDLE only)
//  a        in   WIDTH  operand A, sampled on the accepted start edge only
//  b        in   WIDTH  operand B, sampled on the accepted start edge only
//  cin      in   1      carry-in, sampled on the accepted start edge only
//  busy     out  1      high while state == RUN
//  done     out  1      one-cycle pulse: sum/cout valid
//  sum_bit  out  1      registered serial sum bit produced by the last RUN edge
//  sum      out  WIDTH  parallel result; held stable from done until next accepted start
//  cout     out  1      final carry-out; same hold rule as sum
// BEHAVIOUR
//  - Reset: rst sampled high on posedge clk -> state=IDLE; busy, done, sum_bit, sum,
//    cout, carry reg, shift regs and bit counter all 0. rst overrides start and everything else.
//  - FSM states: IDLE, RUN, DONE (2-bit encoding).
//    IDLE: start=1 -> load sh_a<=a, sh_b<=b, carry<=cin, cnt<=0, sum<=0 -> RUN.
//    RUN : each edge: s=sh_a[0]^sh_b[0]^carry; c=maj(sh_a[0],sh_b[0],carry);
//          sh_a, sh_b shift right by 1 (0 in at MSB); sum<={s,sum[WIDTH-1:1]};
//          sum_bit<=s; carry<=c; cnt<=cnt+1. When cnt==WIDTH-1: cout<=c -> DONE.
//    DONE: done=1 for exactly this cycle; unconditional -> IDLE on next edge.
//  - Latency: start accepted on edge E0 -> busy high after E0 for WIDTH cycles;
//    done high after edge E0+WIDTH for one cycle. Min start-to-start spacing WIDTH+2 cycles.
//  - start while RUN or DONE: ignored, not queued; operands/result unaffected.
//  - a/b/cin changes outside the accepted start edge: no effect.
//  - cnt width = $clog2(WIDTH)+1; no wrap inside an operation.
//  - WIDTH=1: single RUN cycle; done one edge after it.
//  - Arithmetic: {cout,sum} == a + b + cin exactly (modulo 2^(WIDTH+1)); no overflow flag.
//  - sum and cout update during RUN (partial values visible); only valid while done=1
//    and afterwards until the next accepted start.
//  - Reset mid-RUN: operation aborted, all outputs 0 on next cycle, no done pulse.
//  - busy and done never high simultaneously; done never high without a preceding busy.
// TESTING
//  1. WIDTH=8, a=8'h3C, b=8'h5A, cin=0, pulse start -> done 8 cycles after start edge,
//     sum=8'h96, cout=0; sum_bit sequence LSB-first 0,1,1,0,1,0,0,1.
//  2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1 (carry ripples through all 8 bits).
//  3. a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1; a=0,b=0,cin=1 -> sum=8'h01, cout=0.
//  4. Start 0x10+0x20, re-assert start with a=8'hAA,b=8'h55 during RUN and in the DONE cycle
//     -> ignored, sum=8'h30, cout=0; start in following IDLE cycle accepted -> sum=8'hFF.
//  5. Assert rst on 4th RUN cycle -> next cycle busy=0, done=0, sum=0, cout=0, state IDLE;
//     no done pulse; a fresh start then completes normally.
//  6. Random: 1000 operand triples at WIDTH=8 and WIDTH=1 vs reference a+b+cin model;
//     check {cout,sum}, done pulse width 1, busy duration == WIDTH cycles.

Source files
------------

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: LSB-first add of two WIDTH-bit operands through one full-adder cell.
// Latency: start accepted on edge E0, done pulses for one cycle after edge E0+WIDTH.
// Backpressure: none; start is honoured only in IDLE, otherwise dropped (never queued).
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic             sum_bit,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] sum_shift;

    // The single full-adder cell; everything else just feeds it one bit per cycle.
    always_comb begin
        fa_s = sh_a[0] ^ sh_b[0] ^ carry;
        fa_c = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
    end

    // New sum bit enters at the MSB; written this way so WIDTH=1 needs no special case.
    always_comb begin
        sum_shift            = sum >> 1;
        sum_shift[WIDTH-1]   = fa_s;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a    <= '0;
            sh_b    <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            sum_bit <= 1'b0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                    end
                end
                RUN: begin
                    sh_a    <= sh_a >> 1;
                    sh_b    <= sh_b >> 1;
                    sum     <= sum_shift;
                    sum_bit <= fa_s;
                    carry   <= fa_c;
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST) cout <= fa_c;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and random checks of bit_serial_adder at WIDTH=8 and WIDTH=1.
module tb_bit_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, busy8, done8, sum_bit8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, sum_bit1, cout1;
    logic [0:0] a1, b1, sum1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum_bit(sum_bit8), .sum(sum8), .cout(cout8)
    );

    bit_serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum_bit(sum_bit1), .sum(sum1), .cout(cout1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one WIDTH=8 add and collect what it produced; operands are scrambled after E0.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        output logic [7:0] rs, output logic rc, output logic [7:0] bits,
                        output int lat, output int bcnt, output logic overlap,
                        output logic wide);
        a8 = ta; b8 = tb_; cin8 = tc; start8 = 1'b1;
        tick();
        start8 = 1'b0; a8 = ~ta; b8 = ~tb_; cin8 = ~tc;
        bits = '0; lat = -1; bcnt = 0; overlap = 1'b0; wide = 1'b0; rs = '0; rc = 1'b0;
        if (busy8) bcnt++;
        if (done8) overlap = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick();
            if (cyc <= 8) bits[cyc-1] = sum_bit8;
            if (busy8 && done8) overlap = 1'b1;
            if (done8) begin
                lat = cyc; rs = sum8; rc = cout8;
                break;
            end
            if (busy8) bcnt++;
        end
        if (lat > 0) begin
            tick();
            wide = done8;
        end
    endtask

    task automatic run1(input logic ta, input logic tb_, input logic tc,
                        output logic rs, output logic rc, output logic rbit,
                        output int lat, output int bcnt, output logic wide);
        a1 = ta; b1 = tb_; cin1 = tc; start1 = 1'b1;
        tick();
        start1 = 1'b0; a1 = ~ta; b1 = ~tb_; cin1 = ~tc;
        lat = -1; bcnt = 0; wide = 1'b0; rs = 1'b0; rc = 1'b0; rbit = 1'b0;
        if (busy1) bcnt++;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            tick();
            if (done1) begin
                lat = cyc; rs = sum1[0]; rc = cout1; rbit = sum_bit1;
                break;
            end
            if (busy1) bcnt++;
        end
        if (lat > 0) begin
            tick();
            wide = done1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        tick(); tick();
        checks++;
        if ({busy8, done8, sum_bit8, sum8, cout8} !== 12'h000) begin
            errors++;
            $display("FAIL reset_w8 got busy=%b done=%b bit=%b sum=%h cout=%b, want all 0",
                     busy8, done8, sum_bit8, sum8, cout8);
        end
        checks++;
        if ({busy1, done1, sum_bit1, sum1, cout1} !== 5'b0) begin
            errors++;
            $display("FAIL reset_w1 got busy=%b done=%b bit=%b sum=%b cout=%b, want all 0",
                     busy1, done1, sum_bit1, sum1, cout1);
        end
        start8 = 1'b0; start1 = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] rs, bits;
        logic rc, ov, wide;
        int lat, bcnt;
        run8(8'h3C, 8'h5A, 1'b0, rs, rc, bits, lat, bcnt, ov, wide);
        checks++;
        if ({rc, rs} !== 9'h096) begin
            errors++;
            $display("FAIL basic_sum got %b_%h want 0_96", rc, rs);
        end
        checks++;
        if (bits !== 8'h96) begin
            errors++;
            $display("FAIL basic_serial_bits got %b want 10010110", bits);
        end
        checks++;
        if (lat != 8 || bcnt != 8) begin
            errors++;
            $display("FAIL basic_latency got done@%0d busy=%0d want done@8 busy=8", lat, bcnt);
        end
        checks++;
        if (ov || wide) begin
            errors++;
            $display("FAIL basic_done_pulse got overlap=%b wide=%b want 0 0", ov, wide);
        end
    endtask

    task automatic test_carry();
        logic [7:0] rs, bits;
        logic rc, ov, wide;
        int lat, bcnt;
        run8(8'hFF, 8'h01, 1'b0, rs, rc, bits, lat, bcnt, ov, wide);
        checks++;
        if ({rc, rs} !== 9'h100) begin
            errors++;
            $display("FAIL ripple_ff_01 got %b_%h want 1_00", rc, rs);
        end
        run8(8'hFF, 8'hFF, 1'b1, rs, rc, bits, lat, bcnt, ov, wide);
        checks++;
        if ({rc, rs} !== 9'h1FF) begin
            errors++;
            $display("FAIL max_ff_ff_1 got %b_%h want 1_ff", rc, rs);
        end
        run8(8'h00, 8'h00, 1'b1, rs, rc, bits, lat, bcnt, ov, wide);
        checks++;
        if ({rc, rs} !== 9'h001) begin
            errors++;
            $display("FAIL cin_only got %b_%h want 0_01", rc, rs);
        end
    endtask

    task automatic test_start_ignored();
        logic [7:0] rs, bits;
        logic rc, ov, wide;
        int lat, bcnt, n;
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick();
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        n = 0;
        while (!done8 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!done8 || {cout8, sum8} !== 9'h030) begin
            errors++;
            $display("FAIL ignore_during_run got done=%b %b_%h want done=1 0_30",
                     done8, cout8, sum8);
        end
        tick();
        checks++;
        if (busy8 || done8 || {cout8, sum8} !== 9'h030) begin
            errors++;
            $display("FAIL ignore_in_done got busy=%b done=%b %b_%h want 0 0 0_30",
                     busy8, done8, cout8, sum8);
        end
        run8(8'hAA, 8'h55, 1'b0, rs, rc, bits, lat, bcnt, ov, wide);
        checks++;
        if ({rc, rs} !== 9'h0FF || lat != 8) begin
            errors++;
            $display("FAIL accept_after_done got %b_%h done@%0d want 0_ff done@8", rc, rs, lat);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] rs, bits;
        logic rc, ov, wide, seen;
        int lat, bcnt;
        a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy8, done8, sum_bit8, sum8, cout8} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_run got busy=%b done=%b bit=%b sum=%h cout=%b, want all 0",
                     busy8, done8, sum_bit8, sum8, cout8);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_no_done got activity=1 want 0");
        end
        run8(8'h12, 8'h34, 1'b1, rs, rc, bits, lat, bcnt, ov, wide);
        checks++;
        if ({rc, rs} !== 9'h047 || lat != 8) begin
            errors++;
            $display("FAIL after_reset_run got %b_%h done@%0d want 0_47 done@8", rc, rs, lat);
        end
    endtask

    task automatic test_width1();
        logic rs, rc, rbit, wide;
        int lat, bcnt;
        logic [1:0] exp;
        for (int v = 0; v < 8; v++) begin
            run1(v[2], v[1], v[0], rs, rc, rbit, lat, bcnt, wide);
            exp = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
            checks++;
            if ({rc, rs} !== exp || rbit !== exp[0] || lat != 1 || bcnt != 1 || wide) begin
                errors++;
                $display("FAIL w1_vec%0d got %b%b bit=%b done@%0d busy=%0d wide=%b want %b bit=%b done@1 busy=1 wide=0",
                         v, rc, rs, rbit, lat, bcnt, wide, exp, exp[0]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] ra, rb, rs, bits;
        logic rcin, rc, ov, wide, r1s, r1c, r1b;
        logic [8:0] exp;
        logic [1:0] exp1;
        int lat, bcnt;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rcin = 1'($urandom);
            run8(ra, rb, rcin, rs, rc, bits, lat, bcnt, ov, wide);
            exp = 9'(ra) + 9'(rb) + 9'(rcin);
            checks++;
            if ({rc, rs} !== exp || bits !== exp[7:0]) begin
                errors++;
                $display("FAIL rand8_sum %h+%h+%b got %b_%h bits=%h want %h",
                         ra, rb, rcin, rc, rs, bits, exp);
            end
            checks++;
            if (lat != 8 || bcnt != 8 || ov || wide) begin
                errors++;
                $display("FAIL rand8_timing got done@%0d busy=%0d ov=%b wide=%b want 8 8 0 0",
                         lat, bcnt, ov, wide);
            end
        end
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rcin = 1'($urandom);
            run1(ra[0], rb[0], rcin, r1s, r1c, r1b, lat, bcnt, wide);
            exp1 = 2'(ra[0]) + 2'(rb[0]) + 2'(rcin);
            checks++;
            if ({r1c, r1s} !== exp1 || lat != 1 || bcnt != 1 || wide) begin
                errors++;
                $display("FAIL rand1 %b+%b+%b got %b%b done@%0d busy=%0d wide=%b want %b done@1 busy=1",
                         ra[0], rb[0], rcin, r1c, r1s, lat, bcnt, wide, exp1);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_start_ignored();
        test_reset_mid_run();
        test_width1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
